deser_lane_arbiter: RTL and testbench

Shares one 16-bit serial-to-parallel deserializer (single-bit data/valid in, word plus one-cycle valid strobe out) between N serial requester lanes. The block grants one lane at a time with round-robin priority and forwards that lane's bitstream to the deserializer for exactly one DATA_W-bit word. It then returns the completed word tagged with the lane index. Stalled or withdrawn transfers are aborted with a deserializer flush. It sits directly in front of the deserializer in the receive datapath.

---
 rtl/deser_lane_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_deser_lane_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_lane_arbiter.sv
// -----------------------------------------------------------------------------
// deser_lane_arbiter
//
// Shares one serial-to-parallel deserializer between N_LANES serial requester
// lanes. Lanes are granted one at a time with round-robin priority. The
// granted lane's bitstream is forwarded to the deserializer for exactly one
// DATA_W-bit word. The finished word is returned tagged with the lane index.
// Stalled or withdrawn transfers are aborted, and the deserializer is flushed
// through its synchronous reset.
//
// State table
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no grant; pick next requester from the round-robin pointer
//   ST_STREAM | granted lane's bits forwarded, counting bits and idle gaps
//   ST_WAIT   | all bits sent; waiting for the deserializer word strobe
//   ST_ABORT  | one cycle: flush deserializer, pulse abort_o, advance pointer
//
// Ports
//   clk               system clock, rising edge
//   arst_n_i          asynchronous reset, active low
//   req_i             per-lane request, held high for the whole word
//   data_i            per-lane serial data bit
//   data_val_i        per-lane bit valid
//   gnt_o             one-hot grant (registered)
//   ser_data_o        data bit to deserializer (granted lane only)
//   ser_data_val_o    bit valid to deserializer (granted lane only)
//   deser_srst_o      synchronous reset to deserializer (registered)
//   deser_data_i      word from deserializer
//   deser_data_val_i  word strobe from deserializer
//   word_o            delivered word, held between strobes
//   word_val_o        one-cycle strobe for word_o
//   word_lane_o       lane that produced word_o
//   abort_o           one-cycle strobe on abort
//   busy_o            high in any state other than ST_IDLE
// -----------------------------------------------------------------------------
module deser_lane_arbiter #(
    parameter int N_LANES  = 4,
    parameter int DATA_W   = 16,
    parameter int TIMEOUT  = 64,
    parameter int WAIT_MAX = 4
) (
    input  logic                       clk,
    input  logic                       arst_n_i,
    input  logic [N_LANES-1:0]         req_i,
    input  logic [N_LANES-1:0]         data_i,
    input  logic [N_LANES-1:0]         data_val_i,
    output logic [N_LANES-1:0]         gnt_o,
    output logic                       ser_data_o,
    output logic                       ser_data_val_o,
    output logic                       deser_srst_o,
    input  logic [DATA_W-1:0]          deser_data_i,
    input  logic                       deser_data_val_i,
    output logic [DATA_W-1:0]          word_o,
    output logic                       word_val_o,
    output logic [$clog2(N_LANES)-1:0] word_lane_o,
    output logic                       abort_o,
    output logic                       busy_o
);

    localparam int LW  = $clog2(N_LANES);
    localparam int LW1 = LW + 1;
    localparam int BW  = $clog2(DATA_W);
    localparam int IW  = $clog2(TIMEOUT + 1);
    localparam int WW  = $clog2(WAIT_MAX + 1);

    localparam logic [LW-1:0] LANE_LAST = LW'(N_LANES - 1);
    localparam logic [LW:0]   N_LANES_W = LW1'(N_LANES);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_LANES-1:0]  gnt_q, gnt_d;
    logic [LW-1:0]       lane_q, lane_d;
    logic [LW-1:0]       ptr_q, ptr_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]       idle_cnt_q, idle_cnt_d;
    logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                word_val_q, word_val_d;
    logic [LW-1:0]       word_lane_q, word_lane_d;
    logic                abort_q, abort_d;
    logic                srst_q, srst_d;

    logic [2*N_LANES-1:0] req_dbl;
    logic [N_LANES-1:0]   req_rot;
    logic [LW-1:0]        rr_off;
    logic [LW:0]          rr_sum;
    logic [LW-1:0]        rr_lane;
    logic                 rr_any;
    logic                 lane_vbit;
    logic                 lane_req;
    logic [LW-1:0]        lane_next;

    // Round-robin pick: rotate the requests so the pointer lane sits at bit 0,
    // take the lowest set bit, then rotate the offset back.
    always_comb begin
        req_dbl = {req_i, req_i};
        req_rot = N_LANES'(req_dbl >> ptr_q);
        rr_any  = |req_i;
        rr_off  = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rr_off = LW'(i);
            end
        end
        rr_sum  = {1'b0, ptr_q} + {1'b0, rr_off};
        rr_lane = (rr_sum >= N_LANES_W) ? LW'(rr_sum - N_LANES_W) : LW'(rr_sum);
    end

    always_comb begin
        lane_vbit = data_val_i[lane_q];
        lane_req  = req_i[lane_q];
        lane_next = (lane_q == LANE_LAST) ? '0 : lane_q + LW'(1);
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        lane_d      = lane_q;
        ptr_d       = ptr_q;
        bit_cnt_d   = bit_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        word_d      = word_q;
        word_val_d  = 1'b0;
        word_lane_d = word_lane_q;

        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    state_d          = ST_STREAM;
                    lane_d           = rr_lane;
                    gnt_d            = '0;
                    gnt_d[rr_lane]   = 1'b1;
                    bit_cnt_d        = '0;
                    idle_cnt_d       = '0;
                end
            end

            ST_STREAM: begin
                // Completion wins over a request drop in the same cycle.
                if (lane_vbit && (bit_cnt_q == BIT_LAST)) begin
                    state_d    = ST_WAIT;
                    gnt_d      = '0;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    wait_cnt_d = WAIT_LOAD;
                end else if (!lane_req) begin
                    gnt_d      = '0;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    if (bit_cnt_q == '0) begin
                        // Nothing reached the deserializer yet: clean release.
                        state_d = ST_IDLE;
                        ptr_d   = lane_next;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end else if (!lane_vbit && (idle_cnt_q == IDLE_LAST)) begin
                    state_d    = ST_ABORT;
                    gnt_d      = '0;
                end else if (lane_vbit) begin
                    bit_cnt_d  = bit_cnt_q + BW'(1);
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end

            ST_WAIT: begin
                if (deser_data_val_i) begin
                    state_d     = ST_IDLE;
                    word_d      = deser_data_i;
                    word_lane_d = lane_q;
                    word_val_d  = 1'b1;
                    ptr_d       = lane_next;
                end else if (wait_cnt_q == '0) begin
                    state_d = ST_ABORT;
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end

            ST_ABORT: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                ptr_d      = lane_next;
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                wait_cnt_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        // Both strobes are registered so they line up with the ST_ABORT cycle.
        abort_d = (state_d == ST_ABORT);
        srst_d  = (state_d == ST_ABORT);
    end

    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            lane_q      <= '0;
            ptr_q       <= '0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            word_q      <= '0;
            word_val_q  <= 1'b0;
            word_lane_q <= '0;
            abort_q     <= 1'b0;
            srst_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            lane_q      <= lane_d;
            ptr_q       <= ptr_d;
            bit_cnt_q   <= bit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            word_q      <= word_d;
            word_val_q  <= word_val_d;
            word_lane_q <= word_lane_d;
            abort_q     <= abort_d;
            srst_q      <= srst_d;
        end
    end

    // Forwarding is masked by the registered grant, so an ungranted lane can
    // never reach the deserializer and nothing is forwarded outside ST_STREAM.
    assign ser_data_o     = |(data_i & gnt_q);
    assign ser_data_val_o = |(data_val_i & gnt_q);

    assign gnt_o        = gnt_q;
    assign deser_srst_o = srst_q;
    assign word_o       = word_q;
    assign word_val_o   = word_val_q;
    assign word_lane_o  = word_lane_q;
    assign abort_o      = abort_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_deser_lane_arbiter.sv
module tb_deser_lane_arbiter;

    logic        clk = 1'b0;
    logic        arst_n_i = 1'b1;
    logic [3:0]  req_i = '0;
    logic [3:0]  data_i = '0;
    logic [3:0]  data_val_i = '0;
    logic [3:0]  gnt_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        deser_srst_o;
    logic [15:0] deser_data_i;
    logic        deser_data_val_i;
    logic [15:0] word_o;
    logic        word_val_o;
    logic [1:0]  word_lane_o;
    logic        abort_o;
    logic        busy_o;

    // deserializer model: 16-bit MSB-first shifter, 1-cycle strobe latency
    logic [15:0] dm_sh = '0;
    logic [15:0] dm_word = '0;
    int          dm_cnt = 0;
    logic        dm_val = 1'b0;
    logic        dm_mute = 1'b0;
    logic        inj_val = 1'b0;
    logic [15:0] inj_data = '0;
    logic        s_val = 1'b0;
    logic        s_dat = 1'b0;
    logic        s_srst = 1'b1;

    int          checks = 0;
    int          errors = 0;
    int          wv_count = 0;
    int          ab_count = 0;
    int          leak = 0;
    int          fwd = 0;
    logic [3:0]  first_gnt = '0;
    logic [15:0] word_tab [8];
    logic [15:0] rec_word [8];
    int          rec_lane [8];

    assign deser_data_val_i = dm_val | inj_val;
    assign deser_data_i     = inj_val ? inj_data : dm_word;

    deser_lane_arbiter dut (
        .clk              (clk),
        .arst_n_i         (arst_n_i),
        .req_i            (req_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .gnt_o            (gnt_o),
        .ser_data_o       (ser_data_o),
        .ser_data_val_o   (ser_data_val_o),
        .deser_srst_o     (deser_srst_o),
        .deser_data_i     (deser_data_i),
        .deser_data_val_i (deser_data_val_i),
        .word_o           (word_o),
        .word_val_o       (word_val_o),
        .word_lane_o      (word_lane_o),
        .abort_o          (abort_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Inputs change only at negedge, so a snapshot taken shortly after it holds
    // exactly what the deserializer sees at the following rising edge.
    always @(negedge clk) begin
        #2;
        s_val  = ser_data_val_o;
        s_dat  = ser_data_o;
        s_srst = deser_srst_o;
    end

    always @(posedge clk) begin
        if (s_srst) begin
            dm_sh  <= '0;
            dm_cnt <= 0;
            dm_val <= 1'b0;
        end else begin
            dm_val <= 1'b0;
            if (s_val) begin
                dm_sh <= {dm_sh[14:0], s_dat};
                if (dm_cnt == 15) begin
                    dm_cnt  <= 0;
                    dm_word <= {dm_sh[14:0], s_dat};
                    dm_val  <= !dm_mute;
                end else begin
                    dm_cnt <= dm_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (word_val_o) wv_count++;
        if (abort_o) ab_count++;
    end

    // Stimulus driver: grants are served from word_tab in order of issue;
    // ungranted lanes carry noise with valid high.
    task automatic run_words(input logic [3:0] mask, input int n, input int gap_pct, output int got);
        int k = -1;
        int bidx = 0;
        int cycles = 0;
        logic [3:0] prev = '0;
        logic v;
        got = 0;
        req_i = mask;
        while (got < n && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (word_val_o) begin
                rec_word[got] = word_o;
                rec_lane[got] = int'(word_lane_o);
                got++;
                if (got == n) req_i = '0;
            end
            if (gnt_o != '0 && gnt_o != prev) begin
                k++;
                bidx = 0;
                if (k == 0) first_gnt = gnt_o;
            end
            prev = gnt_o;
            for (int l = 0; l < 4; l++) begin
                if (gnt_o[l]) begin
                    if (bidx < 16 && k < 8) begin
                        v = (int'($urandom_range(99)) >= gap_pct);
                        data_i[l]     = word_tab[k][15-bidx];
                        data_val_i[l] = v;
                        if (v) bidx++;
                    end else begin
                        data_val_i[l] = 1'b0;
                    end
                end else begin
                    data_i[l]     = 1'($urandom_range(1));
                    data_val_i[l] = 1'b1;
                end
            end
            #1;
            if (gnt_o == '0 && ser_data_val_o) leak++;
            if (gnt_o != '0 && ser_data_val_o) fwd++;
        end
        req_i = '0;
        data_val_i = '0;
    endtask

    task automatic wait_gnt(output int c);
        c = 0;
        while (gnt_o == '0 && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic send_bits(input int lane, input logic [15:0] w, input int n);
        for (int b = 0; b < n; b++) begin
            data_i[lane]     = w[15-b];
            data_val_i[lane] = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 arst_n_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt_o); end
        checks++; if (ser_data_o !== 1'b0 || ser_data_val_o !== 1'b0) begin errors++; $display("FAIL rst_ser got %b%b exp 00", ser_data_o, ser_data_val_o); end
        checks++; if (word_o !== 16'h0000) begin errors++; $display("FAIL rst_word got %h exp 0000", word_o); end
        checks++; if (word_val_o !== 1'b0 || abort_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_strobes got wv=%b ab=%b busy=%b exp 0", word_val_o, abort_o, busy_o); end
        checks++; if (word_lane_o !== 2'd0) begin errors++; $display("FAIL rst_lane got %0d exp 0", word_lane_o); end
        checks++; if (deser_srst_o !== 1'b1) begin errors++; $display("FAIL rst_srst got %b exp 1", deser_srst_o); end
        arst_n_i = 1'b1;
        #1;
        checks++; if (deser_srst_o !== 1'b1) begin errors++; $display("FAIL rst_srst_hold got %b exp 1", deser_srst_o); end
        @(negedge clk);
        checks++; if (deser_srst_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rst_release got srst=%b busy=%b exp 0 0", deser_srst_o, busy_o); end
        inj_data = 16'hFFFF;
        inj_val  = 1'b1;
        @(negedge clk);
        inj_val  = 1'b0;
        checks++; if (word_val_o !== 1'b0 || word_o !== 16'h0000) begin errors++; $display("FAIL idle_strobe_ignored got wv=%b word=%h exp 0 0000", word_val_o, word_o); end
    endtask

    task automatic test_round_robin();
        int got;
        int exp_lane [5] = '{0, 1, 2, 3, 0};
        word_tab[0] = 16'h1234; word_tab[1] = 16'hBEEF; word_tab[2] = 16'h0F0F;
        word_tab[3] = 16'h8001; word_tab[4] = 16'h7E5A;
        leak = 0;
        run_words(4'b1111, 5, 0, got);
        checks++; if (got != 5) begin errors++; $display("FAIL rr_count got %0d exp 5", got); end
        for (int i = 0; i < 5; i++) begin
            if (i < got) begin
                checks++; if (rec_lane[i] != exp_lane[i]) begin errors++; $display("FAIL rr_lane[%0d] got %0d exp %0d", i, rec_lane[i], exp_lane[i]); end
                checks++; if (rec_word[i] !== word_tab[i]) begin errors++; $display("FAIL rr_word[%0d] got %h exp %h", i, rec_word[i], word_tab[i]); end
            end
        end
        checks++; if (leak != 0) begin errors++; $display("FAIL rr_leak got %0d exp 0", leak); end
    endtask

    task automatic test_single_lane();
        int got;
        int wv0;
        word_tab[0] = 16'hA5C3;
        first_gnt = '0;
        wv0 = wv_count;
        run_words(4'b0010, 1, 0, got);
        checks++; if (got != 1) begin errors++; $display("FAIL single_count got %0d exp 1", got); end
        checks++; if (first_gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt got %b exp 0010", first_gnt); end
        checks++; if (rec_word[0] !== 16'hA5C3) begin errors++; $display("FAIL single_word got %h exp a5c3", rec_word[0]); end
        checks++; if (rec_lane[0] != 1) begin errors++; $display("FAIL single_lane got %0d exp 1", rec_lane[0]); end
        @(negedge clk);
        checks++; if (word_val_o !== 1'b0 || gnt_o !== 4'b0000) begin errors++; $display("FAIL single_after got wv=%b gnt=%b exp 0 0000", word_val_o, gnt_o); end
        checks++; if (wv_count - wv0 != 1) begin errors++; $display("FAIL single_pulses got %0d exp 1", wv_count - wv0); end
        checks++; if (word_o !== 16'hA5C3) begin errors++; $display("FAIL single_hold got %h exp a5c3", word_o); end
    endtask

    task automatic test_gapped();
        int got;
        word_tab[0] = 16'hC0DE;
        leak = 0;
        fwd  = 0;
        run_words(4'b0100, 1, 50, got);
        checks++; if (got != 1) begin errors++; $display("FAIL gap_count got %0d exp 1", got); end
        checks++; if (rec_word[0] !== 16'hC0DE || rec_lane[0] != 2) begin errors++; $display("FAIL gap_word got %h/%0d exp c0de/2", rec_word[0], rec_lane[0]); end
        checks++; if (fwd != 16) begin errors++; $display("FAIL gap_valid_bits got %0d exp 16", fwd); end
        checks++; if (leak != 0) begin errors++; $display("FAIL gap_leak got %0d exp 0", leak); end
    endtask

    task automatic test_timeout();
        int c;
        int ab0 = ab_count;
        int wv0 = wv_count;
        data_val_i = '0;
        req_i = 4'b0011;
        wait_gnt(c);
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL to_gnt got %b exp 0001", gnt_o); end
        send_bits(0, 16'hA800, 5);
        data_val_i = '0;
        c = 0;
        while (abort_o !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++; if (c != 64) begin errors++; $display("FAIL to_idle_cycles got %0d exp 64", c); end
        checks++; if (deser_srst_o !== 1'b1) begin errors++; $display("FAIL to_srst got %b exp 1", deser_srst_o); end
        @(negedge clk);
        checks++; if (abort_o !== 1'b0 || deser_srst_o !== 1'b0 || gnt_o !== 4'b0000) begin errors++; $display("FAIL to_after got ab=%b srst=%b gnt=%b exp 0 0 0000", abort_o, deser_srst_o, gnt_o); end
        @(negedge clk);
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL to_next_gnt got %b exp 0010", gnt_o); end
        req_i = '0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || abort_o !== 1'b0) begin errors++; $display("FAIL release got busy=%b ab=%b exp 0 0", busy_o, abort_o); end
        checks++; if (ab_count - ab0 != 1 || wv_count != wv0) begin errors++; $display("FAIL to_pulses got ab=%0d wv=%0d exp 1 0", ab_count - ab0, wv_count - wv0); end
    endtask

    task automatic test_wait_timeout();
        int c;
        int wv0 = wv_count;
        dm_mute = 1'b1;
        req_i = 4'b0001;
        wait_gnt(c);
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL wt_gnt got %b exp 0001", gnt_o); end
        send_bits(0, 16'h3C3C, 16);
        data_val_i = '0;
        #1;
        checks++; if (busy_o !== 1'b1 || gnt_o !== 4'b0000 || ser_data_val_o !== 1'b0) begin errors++; $display("FAIL wt_wait got busy=%b gnt=%b sv=%b exp 1 0000 0", busy_o, gnt_o, ser_data_val_o); end
        c = 0;
        while (abort_o !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        req_i = '0;
        checks++; if (c != 4) begin errors++; $display("FAIL wt_cycles got %0d exp 4", c); end
        @(negedge clk);
        dm_mute = 1'b0;
        checks++; if (wv_count != wv0 || busy_o !== 1'b0) begin errors++; $display("FAIL wt_after got wv=%0d busy=%b exp 0 0", wv_count - wv0, busy_o); end
    endtask

    task automatic test_mid_drop();
        int c;
        int wv0 = wv_count;
        req_i = 4'b1000;
        wait_gnt(c);
        checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL drop_gnt got %b exp 1000", gnt_o); end
        send_bits(3, 16'h5A5A, 8);
        req_i = '0;
        data_val_i = '0;
        @(negedge clk);
        checks++; if (abort_o !== 1'b1 || deser_srst_o !== 1'b1) begin errors++; $display("FAIL drop_abort got ab=%b srst=%b exp 1 1", abort_o, deser_srst_o); end
        @(negedge clk);
        checks++; if (abort_o !== 1'b0 || busy_o !== 1'b0 || wv_count != wv0) begin errors++; $display("FAIL drop_after got ab=%b busy=%b wv=%0d exp 0 0 0", abort_o, busy_o, wv_count - wv0); end
    endtask

    task automatic test_arst_in_wait();
        int c;
        int wv0 = wv_count;
        dm_mute = 1'b1;
        req_i = 4'b1000;
        wait_gnt(c);
        checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL arst_gnt got %b exp 1000", gnt_o); end
        send_bits(3, 16'hF00D, 16);
        data_val_i = '0;
        req_i = '0;
        #1;
        checks++; if (busy_o !== 1'b1 || gnt_o !== 4'b0000) begin errors++; $display("FAIL arst_pre got busy=%b gnt=%b exp 1 0000", busy_o, gnt_o); end
        arst_n_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || deser_srst_o !== 1'b1 || word_o !== 16'h0000) begin errors++; $display("FAIL arst_now got busy=%b srst=%b word=%h exp 0 1 0000", busy_o, deser_srst_o, word_o); end
        checks++; if (word_val_o !== 1'b0 || abort_o !== 1'b0 || word_lane_o !== 2'd0) begin errors++; $display("FAIL arst_strobes got wv=%b ab=%b lane=%0d exp 0 0 0", word_val_o, abort_o, word_lane_o); end
        repeat (3) @(negedge clk);
        arst_n_i = 1'b1;
        @(negedge clk);
        dm_mute = 1'b0;
        checks++; if (deser_srst_o !== 1'b0 || busy_o !== 1'b0 || wv_count != wv0) begin errors++; $display("FAIL arst_after got srst=%b busy=%b wv=%0d exp 0 0 0", deser_srst_o, busy_o, wv_count - wv0); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_lane();
        test_gapped();
        test_timeout();
        test_wait_timeout();
        test_mid_drop();
        test_arst_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
